// File: rtl/crp16_alu_pkg.sv
// Shared constants for the crp16 logic-unit pipeline: op-code encoding,
// op width and flag bit positions.
package crp16_alu_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned FLAG_W = 3;

    // Codes 000-011 are bit-identical to the legacy crp16 logic select.
    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NOT  = 3'b010,
        OP_XOR  = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_XNOR = 3'b110,
        OP_ANDN = 3'b111
    } op_e;

    localparam int unsigned FLAG_ZERO = 0;
    localparam int unsigned FLAG_NEG  = 1;
    localparam int unsigned FLAG_PAR  = 2;

endpackage

// File: rtl/crp16_pipe_stage.sv
// One valid/ready register slice. Ready is combinational: the slice can take
// new data when it is empty or when its current content is leaving.
module crp16_pipe_stage #(
    parameter int unsigned DW = 16
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          prev_valid,
    input  logic [DW-1:0] prev_data,
    input  logic          next_ready,
    output logic          ready,
    output logic          valid,
    output logic [DW-1:0] data
);

    assign ready = !valid || next_ready;

    // Valid follows upstream whenever the slice is open; data only moves on a real transfer.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (ready) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data <= prev_data;
            end
        end
    end

endmodule

// File: rtl/crp16_alu_logic_pipe.sv
// Pipelined crp16 bitwise logic unit: 8 ops, WIDTH-bit operands, STAGES
// register slices with valid/ready on both sides and no skid buffer.
// Optional result flags {parity, negative, zero} with CRP16_ALU_LOGIC_FLAGS_EN.
module crp16_alu_logic_pipe
    import crp16_alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  x,
    input  logic [WIDTH-1:0]  y,
    input  logic [OP_W-1:0]   op,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef CRP16_ALU_LOGIC_FLAGS_EN
    output logic [FLAG_W-1:0] flags,
`endif
    output logic [WIDTH-1:0]  out
);

`ifdef CRP16_ALU_LOGIC_FLAGS_EN
    localparam int unsigned DW = WIDTH + FLAG_W;
`else
    localparam int unsigned DW = WIDTH;
`endif

    logic [WIDTH-1:0] result;
    logic [DW-1:0]    stage_in;

    // Op decode: result from the current operands.
    always_comb begin
        result = '0;
        case (op_e'(op))
            OP_AND:  result = x & y;
            OP_OR:   result = x | y;
            OP_NOT:  result = ~x;
            OP_XOR:  result = x ^ y;
            OP_NAND: result = ~(x & y);
            OP_NOR:  result = ~(x | y);
            OP_XNOR: result = ~(x ^ y);
            OP_ANDN: result = x & ~y;
            default: result = '0;
        endcase
    end

`ifdef CRP16_ALU_LOGIC_FLAGS_EN
    logic [FLAG_W-1:0] result_flags;

    // Flags derived from the result so they travel with it through the slices.
    always_comb begin
        result_flags            = '0;
        result_flags[FLAG_ZERO] = (result == '0);
        result_flags[FLAG_NEG]  = result[WIDTH-1];
        result_flags[FLAG_PAR]  = ^result;
    end

    assign stage_in = {result_flags, result};
`else
    assign stage_in = result;
`endif

    // Index 0 is the pipeline input, index STAGES the output side.
    logic [STAGES:0] vld;
    logic [STAGES:0] rdy;
    logic [DW-1:0]   dat [STAGES+1];

    assign vld[0]      = in_valid;
    assign dat[0]      = stage_in;
    assign rdy[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        crp16_pipe_stage #(.DW(DW)) u_stage (
            .clock      (clock),
            .resetn     (resetn),
            .prev_valid (vld[i]),
            .prev_data  (dat[i]),
            .next_ready (rdy[i+1]),
            .ready      (rdy[i]),
            .valid      (vld[i+1]),
            .data       (dat[i+1])
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[STAGES];
    assign out       = dat[STAGES][WIDTH-1:0];
`ifdef CRP16_ALU_LOGIC_FLAGS_EN
    assign flags     = dat[STAGES][WIDTH +: FLAG_W];
`endif

endmodule

// File: tb/tb_crp16_alu_logic_pipe.sv
// Bench for crp16_alu_logic_pipe. Instance 0 (WIDTH=16, STAGES=2) runs the
// directed table and hand sequences; instances 1-4 sweep WIDTH {8,32} x
// STAGES {1,4} with random traffic. Every instance is checked each cycle
// against a queue model: an accepted item is visible STAGES cycles later,
// or one cycle after its predecessor leaves, whichever is later.
module tb_crp16_alu_logic_pipe;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [31:0] val;
        logic [2:0]  flg;
        int          acc;
    } item_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        logic [2:0]  eflg;
    } vec_t;

    function automatic logic [31:0] mask_w(int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] ref_op(logic [2:0] o, logic [31:0] a, logic [31:0] b, int w);
        logic [31:0] r;
        case (o)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = ~a;
            3'd3:    r = a ^ b;
            3'd4:    r = ~(a & b);
            3'd5:    r = ~(a | b);
            3'd6:    r = ~(a ^ b);
            default: r = a & ~b;
        endcase
        return r & mask_w(w);
    endfunction

    // {parity, negative, zero}
    function automatic logic [2:0] ref_flags(logic [31:0] r, int w);
        int ones = 0;
        for (int i = 0; i < w; i++) ones += int'(r[i]);
        return {(ones % 2) == 1, r[w-1], r == 32'd0};
    endfunction

    task automatic chk(int id, string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL inst%0d %s: got %h expected %h", id, name, act, exp);
    endtask

    for (genvar g = 0; g < 5; g++) begin : g_inst
        localparam int W = (g == 0) ? 16 : ((g <= 2) ? 8 : 32);
        localparam int S = (g == 0) ? 2 : (((g % 2) == 1) ? 1 : 4);

        logic         rst_n;
        logic         in_valid;
        logic         in_ready;
        logic         out_valid;
        logic         out_ready;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] out;
        logic [2:0]   op;
`ifdef CRP16_ALU_LOGIC_FLAGS_EN
        logic [2:0]   flags;
`endif
        logic         fin = 1'b0;

        crp16_alu_logic_pipe #(.WIDTH(W), .STAGES(S)) dut (
            .clock     (clock),
            .resetn    (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .x         (x),
            .y         (y),
            .op        (op),
            .out_valid (out_valid),
            .out_ready (out_ready),
`ifdef CRP16_ALU_LOGIC_FLAGS_EN
            .flags     (flags),
`endif
            .out       (out)
        );

        item_t       q[$];
        int          t = 0;
        int          last_leave = -100;
        logic [31:0] last_out = '0;
        logic [2:0]  last_flg = '0;

        // Drive one cycle (called at posedge+1), check at negedge, update model.
        task automatic step(input logic iv, input logic [31:0] xi, input logic [31:0] yi,
                            input logic [2:0] oi, input logic ordy,
                            input logic [31:0] ev, input logic [2:0] ef);
            logic er;
            logic eo;
            in_valid  = iv;
            x         = xi[W-1:0];
            y         = yi[W-1:0];
            op        = oi;
            out_ready = ordy;
            @(negedge clock);
            er = ordy || (q.size() < S);
            eo = (q.size() > 0) && (t >= q[0].acc + S) && (t > last_leave);
            chk(g, "in_ready", in_ready, er);
            chk(g, "out_valid", out_valid, eo);
            if (eo) chk(g, "out", out, q[0].val);
            else    chk(g, "out_hold", out, last_out);
`ifdef CRP16_ALU_LOGIC_FLAGS_EN
            if (eo) chk(g, "flags", flags, q[0].flg);
            else    chk(g, "flags_hold", flags, last_flg);
`endif
            if (iv && er) q.push_back('{val: ev, flg: ef, acc: t});
            if (eo && ordy) begin
                last_out   = q[0].val;
                last_flg   = q[0].flg;
                last_leave = t;
                void'(q.pop_front());
            end
            @(posedge clock);
            #1;
            t++;
        endtask

        task automatic rnd_step(input int ready_pct);
            logic [31:0] a;
            logic [31:0] b;
            logic [2:0]  o;
            logic [31:0] r;
            a = $urandom;
            b = $urandom;
            o = 3'($urandom_range(0, 7));
            r = ref_op(o, a, b, W);
            step(1'($urandom_range(0, 1)), a, b, o,
                 ($urandom_range(0, 99) < ready_pct), r, ref_flags(r, W));
        endtask

        task automatic idle(input int n);
            for (int i = 0; i < n; i++) step(1'b0, '0, '0, 3'd0, 1'b1, '0, '0);
        endtask

        // Asserts reset between clock edges and checks the outputs clear at once.
        task automatic do_reset();
            rst_n     = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            x         = '0;
            y         = '0;
            op        = '0;
            #1;
            chk(g, "rst out_valid", out_valid, 1'b0);
            chk(g, "rst out", out, '0);
`ifdef CRP16_ALU_LOGIC_FLAGS_EN
            chk(g, "rst flags", flags, '0);
`endif
            q.delete();
            last_out   = '0;
            last_flg   = '0;
            last_leave = -100;
            @(posedge clock);
            @(negedge clock);
            rst_n = 1'b1;
            @(posedge clock);
            #1;
            chk(g, "in_ready after reset", in_ready, 1'b1);
        endtask

        if (g == 0) begin : g_dir
            vec_t vecs[10];
            initial begin
                logic [15:0] tbl [8];
                logic [31:0] a;
                logic [31:0] b;
                logic [31:0] r;
                tbl = '{16'h00F0, 16'hFFF0, 16'h0F0F, 16'hFF00,
                        16'hFF0F, 16'h000F, 16'h00FF, 16'hF000};
                for (int i = 0; i < 8; i++)
                    vecs[i] = '{op: 3'(i), a: 16'hF0F0, b: 16'h0FF0,
                                exp: tbl[i], eflg: ref_flags({16'h0, tbl[i]}, 16)};
                vecs[8] = '{op: 3'd0, a: 16'h8000, b: 16'h8001, exp: 16'h8000, eflg: 3'b110};
                vecs[9] = '{op: 3'd3, a: 16'h1234, b: 16'h1234, exp: 16'h0000, eflg: 3'b001};

                do_reset();

                // Eight ops back to back, then the flag vectors.
                for (int i = 0; i < 8; i++)
                    step(1'b1, {16'h0, vecs[i].a}, {16'h0, vecs[i].b}, vecs[i].op, 1'b1,
                         {16'h0, vecs[i].exp}, vecs[i].eflg);
                idle(3);
                for (int i = 8; i < 10; i++)
                    step(1'b1, {16'h0, vecs[i].a}, {16'h0, vecs[i].b}, vecs[i].op, 1'b1,
                         {16'h0, vecs[i].exp}, vecs[i].eflg);
                idle(3);

                // Back-pressure: stream with out_ready low, then drain.
                for (int i = 0; i < 5; i++) begin
                    a = $urandom; b = $urandom; r = ref_op(3'(i), a, b, 16);
                    step(1'b1, a, b, 3'(i), 1'b0, r, ref_flags(r, 16));
                end
                idle(4);

                // Fill, then 20 simultaneous in/out transfers.
                for (int i = 0; i < 22; i++) begin
                    a = $urandom; b = $urandom; r = ref_op(3'(i % 8), a, b, 16);
                    step(1'b1, a, b, 3'(i % 8), (i >= 2), r, ref_flags(r, 16));
                end
                idle(4);

                // Reset with two results in flight.
                for (int i = 0; i < 2; i++) begin
                    a = $urandom; b = $urandom; r = ref_op(3'd3, a, b, 16);
                    step(1'b1, a, b, 3'd3, 1'b0, r, ref_flags(r, 16));
                end
                do_reset();
                idle(4);

                for (int i = 0; i < 300; i++) rnd_step(60);
                idle(6);
                fin = 1'b1;
            end
        end else begin : g_rnd
            initial begin
                do_reset();
                for (int i = 0; i < 1000; i++) rnd_step((i < 500) ? 50 : 85);
                idle(S + 3);
                fin = 1'b1;
            end
        end
    end

    initial begin
        logic all_done;
        all_done = 1'b0;
        for (int c = 0; c < 30000 && !all_done; c++) begin
            @(posedge clock);
            all_done = g_inst[0].fin & g_inst[1].fin & g_inst[2].fin &
                       g_inst[3].fin & g_inst[4].fin;
        end
        if (!all_done) begin
            checks++;
            $display("FAIL timeout: got unfinished expected all instances done");
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
